// File: rtl/dsca_pkg.sv
// Shared types for the duplicated carry-select adder and its checker.
// Error codes, checker FSM states and the default datapath width.
package dsca_pkg;

    localparam int DSCA_W = 64;

    typedef enum logic [1:0] {
        CHK_OK   = 2'b00,
        CHK_PAR  = 2'b01,
        CHK_DUP  = 2'b10,
        CHK_BOTH = 2'b11
    } chk_err_t;

    typedef enum logic {
        RUN   = 1'b0,
        ALARM = 1'b1
    } st_t;

endpackage

// File: rtl/dsca_parity_tree.sv
// Registered bytewise parity of a and bytewise a/b mismatch flags.
// Loads only when en is high so the flags track the stage1 data.
module dsca_parity_tree #(
    parameter int W = 64
) (
    input  logic           clk,
    input  logic           en,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W/8-1:0] byte_par,
    output logic [W/8-1:0] byte_neq
);

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < W / 8; i++) begin
                byte_par[i] <= ^a[i*8 +: 8];
                byte_neq[i] <= |(a[i*8 +: 8] ^ b[i*8 +: 8]);
            end
        end
    end

endmodule

// File: rtl/duplicated_adder_checker_64b.sv
// Two-stage checker for duplicated adder results with sticky alarm and error count.
// DSCA_CHK_ERRLOG_EN adds a first-failure log (log_sum, log_syn, log_err).
module duplicated_adder_checker_64b
    import dsca_pkg::*;
#(
    parameter int W     = DSCA_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     s,
    input  logic [W-1:0]     s_dup,
    input  logic             ps_pred,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output chk_err_t         out_err,
    output logic             alarm,
    input  logic             clr_alarm,
`ifdef DSCA_CHK_ERRLOG_EN
    output logic [W-1:0]     log_sum,
    output logic [W-1:0]     log_syn,
    output chk_err_t         log_err,
`endif
    output logic [CNT_W-1:0] err_cnt
);

    logic           s1_valid;
    logic [W-1:0]   s1_s;
    logic           s1_ps;
    logic [W/8-1:0] s1_bpar;
    logic [W/8-1:0] s1_bneq;
    logic           s1_load;
    logic           s2_adv;
    logic           hs_err;
    st_t            state, state_nx;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !rst && (!s1_valid || s2_adv);
    assign s1_load  = in_valid && in_ready;
    assign hs_err   = out_valid && out_ready && (out_err != CHK_OK);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
        if (s1_load) begin
            s1_s  <= s;
            s1_ps <= ps_pred;
        end
    end

    dsca_parity_tree #(.W(W)) u_ptree (
        .clk      (clk),
        .en       (s1_load),
        .a        (s),
        .b        (s_dup),
        .byte_par (s1_bpar),
        .byte_neq (s1_bneq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_err   <= CHK_OK;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sum <= s1_s;
                out_err <= chk_err_t'({|s1_bneq, (^s1_bpar) ^ s1_ps});
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            RUN:     if (hs_err) state_nx = ALARM;
            ALARM:   if (clr_alarm && !hs_err) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    assign alarm = (state == ALARM);

    // A simultaneous clear and error restarts the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (hs_err) begin
            if (clr_alarm) begin
                err_cnt <= CNT_W'(1);
            end else if (err_cnt != '1) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end else if (clr_alarm) begin
            err_cnt <= '0;
        end
    end

`ifdef DSCA_CHK_ERRLOG_EN
    logic [W-1:0] s1_dup;
    logic [W-1:0] out_syn;

    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_dup <= s_dup;
        end
        if (rst) begin
            out_syn <= '0;
        end else if (s2_adv && s1_valid) begin
            out_syn <= s1_s ^ s1_dup;
        end
    end

    // Capture only the first failure since the last clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            log_sum <= '0;
            log_syn <= '0;
            log_err <= CHK_OK;
        end else if (hs_err && (state == RUN || clr_alarm)) begin
            log_sum <= out_sum;
            log_syn <= out_syn;
            log_err <= out_err;
        end else if (clr_alarm) begin
            log_sum <= '0;
            log_syn <= '0;
            log_err <= CHK_OK;
        end
    end
`endif

endmodule

// File: tb/tb_duplicated_adder_checker_64b.sv
// Directed bench for duplicated_adder_checker_64b (CNT_W=2 to reach saturation).
// Optional log checks compile in with DSCA_CHK_ERRLOG_EN.
module tb_duplicated_adder_checker_64b;
    import dsca_pkg::*;

    localparam int W     = 64;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     s;
    logic [W-1:0]     s_dup;
    logic             ps_pred;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_sum;
    chk_err_t         out_err;
    logic             alarm;
    logic             clr_alarm;
    logic [CNT_W-1:0] err_cnt;
`ifdef DSCA_CHK_ERRLOG_EN
    logic [W-1:0]     log_sum;
    logic [W-1:0]     log_syn;
    chk_err_t         log_err;
`endif

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    duplicated_adder_checker_64b #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .s_dup     (s_dup),
        .ps_pred   (ps_pred),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_err   (out_err),
        .alarm     (alarm),
        .clr_alarm (clr_alarm),
`ifdef DSCA_CHK_ERRLOG_EN
        .log_sum   (log_sum),
        .log_syn   (log_syn),
        .log_err   (log_err),
`endif
        .err_cnt   (err_cnt)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic p);
        in_valid = 1'b1;
        s        = a;
        s_dup    = b;
        ps_pred  = p;
        tick();
        in_valid = 1'b0;
    endtask

    logic [W-1:0] vals [8];
    int sent, got;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        s         = '0;
        s_dup     = '0;
        ps_pred   = 1'b0;
        out_ready = 1'b1;
        clr_alarm = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", out_sum, 64'd0);
        chk("rst_out_err", 64'(out_err), 64'(CHK_OK));
        chk("rst_alarm", 64'(alarm), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // 1: clean result, two-cycle latency
        send(64'h3, 64'h3, 1'b0);
        chk("t1_lat1_valid", 64'(out_valid), 64'd0);
        tick();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_sum", out_sum, 64'h3);
        chk("t1_err", 64'(out_err), 64'(CHK_OK));
        tick();
        chk("t1_alarm", 64'(alarm), 64'd0);
        chk("t1_cnt", 64'(err_cnt), 64'd0);

        // 2: parity error
        send(64'h1, 64'h1, 1'b0);
        tick();
        chk("t2_err", 64'(out_err), 64'(CHK_PAR));
        chk("t2_alarm_pre", 64'(alarm), 64'd0);
        tick();
        chk("t2_alarm", 64'(alarm), 64'd1);
        chk("t2_cnt", 64'(err_cnt), 64'd1);

        // 3: dup-only error, then clear
        send(64'hFF, 64'h7F, 1'b0);
        tick();
        chk("t3_err", 64'(out_err), 64'(CHK_DUP));
        tick();
        chk("t3_cnt", 64'(err_cnt), 64'd2);
        clr_alarm = 1'b1;
        tick();
        clr_alarm = 1'b0;
        chk("t3_clr_alarm", 64'(alarm), 64'd0);
        chk("t3_clr_cnt", 64'(err_cnt), 64'd0);

        // 4: 8 beats back-to-back with out_ready low in cycles 3-6
        for (int i = 0; i < 8; i++)
            vals[i] = 64'h0123_4567_89AB_CDEF ^ (64'h1111 * 64'(i + 1));
        sent = 0;
        got  = 0;
        for (int c = 0; c < 30 && got < 8; c++) begin
            in_valid  = (sent < 8);
            s         = (sent < 8) ? vals[sent] : '0;
            s_dup     = s;
            ps_pred   = ^s;
            out_ready = !(c >= 3 && c <= 6);
            #0;
            if (c == 4) begin
                chk("t4_stall_in_ready", 64'(in_ready), 64'd0);
                chk("t4_stall_sum", out_sum, vals[1]);
            end
            if (out_valid && out_ready) begin
                chk($sformatf("t4_order_%0d", got), out_sum, vals[got]);
                chk($sformatf("t4_err_%0d", got), 64'(out_err), 64'(CHK_OK));
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("t4_count", 64'(got), 64'd8);
        chk("t4_cnt", 64'(err_cnt), 64'd0);

        // 5: saturation at 3, then error+clear in the same cycle
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            s        = 64'(i);
            s_dup    = 64'(i) ^ 64'h100;
            ps_pred  = ^s;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("t5_sat_cnt", 64'(err_cnt), 64'd3);
        chk("t5_alarm", 64'(alarm), 64'd1);
        send(64'h5, 64'h4, 1'b0);
        tick();
        chk("t5_err", 64'(out_err), 64'(CHK_DUP));
        clr_alarm = 1'b1;
        tick();
        clr_alarm = 1'b0;
        chk("t5_clr_err_alarm", 64'(alarm), 64'd1);
        chk("t5_clr_err_cnt", 64'(err_cnt), 64'd1);

        // 6: first-fault log, then reset with beats in flight
        clr_alarm = 1'b1;
        tick();
        clr_alarm = 1'b0;
        chk("t6_clr_alarm", 64'(alarm), 64'd0);
        send(64'hA, 64'h8, 1'b0);
        tick();
        tick();
        chk("t6_alarm", 64'(alarm), 64'd1);
`ifdef DSCA_CHK_ERRLOG_EN
        chk("t6_log_syn", log_syn, 64'h2);
        chk("t6_log_sum", log_sum, 64'hA);
        chk("t6_log_err", 64'(log_err), 64'(CHK_DUP));
`endif
        send(64'hF0, 64'h00, 1'b0);
        tick();
        tick();
        chk("t6_cnt2", 64'(err_cnt), 64'd2);
`ifdef DSCA_CHK_ERRLOG_EN
        chk("t6_log_hold", log_syn, 64'h2);
`endif
        in_valid = 1'b1;
        s        = 64'h77;
        s_dup    = 64'h76;
        ps_pred  = 1'b0;
        tick();
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_alarm", 64'(alarm), 64'd0);
        chk("t6_rst_cnt", 64'(err_cnt), 64'd0);
        chk("t6_rst_in_ready", 64'(in_ready), 64'd0);
`ifdef DSCA_CHK_ERRLOG_EN
        chk("t6_rst_log", log_syn, 64'h0);
`endif
        rst = 1'b0;
        tick();
        chk("t6_flushed", 64'(out_valid), 64'd0);
        chk("t6_in_ready", 64'(in_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
